branch_target_buffer_sa: RTL and testbench

Parametrised set-associative branch target buffer with per-entry 2-bit direction counters and tree pseudo-LRU replacement. Sits beside the fetch stage. Each cycle it takes a fetch key and returns a registered hit, target, branch type and taken prediction. Resolved branches from execute allocate or update entries through a single write port. A one-cycle flush invalidates every entry.

---
 rtl/branch_target_buffer_sa.sv | 236 +++++++++++++++++++++++
 tb/tb_branch_target_buffer_sa.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer_sa.sv
// Purpose : set-associative BTB with 2-bit direction counters and tree pseudo-LRU replacement.
// Latency : 1 cycle, fetch key sampled at edge E, registered result valid after E.
// Backpressure: none; fetch_en=0 holds outputs, the update port is always accepted.
//
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   fetch_en/PC      lookup request and key
//   load, new_*      resolved-branch update (allocate / retarget / train counter)
//   flush            one-cycle invalidate of every entry
//   hit, target, btype, pred_taken   registered lookup result (zeros on miss)
module branch_target_buffer_sa #(
  parameter int KEY_W   = 29,
  parameter int TGT_W   = 30,
  parameter int BTYPE_W = 2,
  parameter int SETS    = 8,
  parameter int WAYS    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [KEY_W-1:0]   fetch_PC,
  input  logic               load,
  input  logic [KEY_W-1:0]   new_PC,
  input  logic [TGT_W-1:0]   new_target,
  input  logic [BTYPE_W-1:0] new_btype,
  input  logic               new_taken,
  input  logic               flush,
  output logic               hit,
  output logic [TGT_W-1:0]   target,
  output logic [BTYPE_W-1:0] btype,
  output logic               pred_taken
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = KEY_W - SET_W;
  localparam int NODES = WAYS - 1;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [TGT_W-1:0]   tgt;
    logic [BTYPE_W-1:0] btype;
    logic [1:0]         ctr;
  } entry_t;

  typedef logic [NODES-1:0] plru_t;

  // Storage. Entry payloads are never reset; valid bits gate every use.
  entry_t          ent_q   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  plru_t           plru_q  [SETS];

  logic               hit_q;
  logic [TGT_W-1:0]   target_q;
  logic [BTYPE_W-1:0] btype_q;
  logic               pred_q;

  // PLRU tree is heap-ordered: node n has children 2n+1 (left) and 2n+2
  // (right). A node bit of 1 points right, i.e. the right subtree is the
  // less recently used one. Way index bits, MSB first, choose the path.
  function automatic plru_t plru_touch(input plru_t t, input logic [WAY_W-1:0] way);
    plru_t r;
    int    n;
    logic  d;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d    = way[WAY_W-1-l];
      r[n] = ~d;             // point away from the touched way
      n    = 2*n + 1 + int'(d);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input plru_t t);
    logic [WAY_W-1:0] r;
    int               n;
    logic             d;
    r = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d              = t[n];
      r[WAY_W-1-l]   = d;
      if (l < WAY_W-1) n = 2*n + 1 + int'(d);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- lookup
  logic [SET_W-1:0] f_set;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [WAY_W-1:0] f_way;

  assign f_set = fetch_PC[SET_W-1:0];
  assign f_tag = fetch_PC[KEY_W-1:SET_W];

  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f_set][w] && ent_q[f_set][w].tag == f_tag) begin
        f_hit = 1'b1;
        f_way = w[WAY_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- update
  logic [SET_W-1:0] u_set;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [WAY_W-1:0] u_way;
  logic             free_vld;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] w_way;
  logic             wr_en;
  logic             upd;
  logic             alloc;
  logic             w_touch;
  logic             lk_touch;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  entry_t           wr_ent;
  plru_t            plru_w_base;

  assign u_set = new_PC[SET_W-1:0];
  assign u_tag = new_PC[KEY_W-1:SET_W];

  always_comb begin
    u_hit    = 1'b0;
    u_way    = '0;
    free_vld = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[u_set][w] && ent_q[u_set][w].tag == u_tag) begin
        u_hit = 1'b1;
        u_way = w[WAY_W-1:0];
      end
    end
    // Scan downward so the last assignment leaves the lowest invalid way.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[u_set][w]) begin
        free_vld = 1'b1;
        free_way = w[WAY_W-1:0];
      end
    end
  end

  // Victim choice uses the PLRU state from before this edge's touches.
  assign victim_way = plru_victim(plru_q[u_set]);

  assign wr_en    = load & ~flush;
  assign upd      = wr_en & u_hit;
  assign alloc    = wr_en & new_taken & ~u_hit;
  assign w_touch  = upd | alloc;
  assign lk_touch = fetch_en & f_hit;
  assign w_way    = u_hit ? u_way : (free_vld ? free_way : victim_way);

  assign ctr_cur = ent_q[u_set][u_way].ctr;

  always_comb begin
    if (new_taken) begin
      ctr_nxt = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
    end else begin
      ctr_nxt = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
    end
  end

  always_comb begin
    wr_ent = ent_q[u_set][u_way];
    if (alloc) begin
      wr_ent.tag   = u_tag;
      wr_ent.tgt   = new_target;
      wr_ent.btype = new_btype;
      wr_ent.ctr   = 2'd2;
    end else begin
      wr_ent.ctr = ctr_nxt;
      if (new_taken) begin
        wr_ent.tgt   = new_target;
        wr_ent.btype = new_btype;
      end
    end
  end

  // When the lookup and the write touch the same set, the write touch is
  // applied on top of the lookup touch so the write's path wins.
  assign plru_w_base = (lk_touch && f_set == u_set) ? plru_touch(plru_q[u_set], f_way)
                                                    : plru_q[u_set];

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      hit_q    <= 1'b0;
      target_q <= '0;
      btype_q  <= '0;
      pred_q   <= 1'b0;
    end else begin
      // Lookup reads pre-edge contents, so it naturally sees no bypass.
      if (fetch_en) begin
        hit_q    <= f_hit;
        target_q <= f_hit ? ent_q[f_set][f_way].tgt   : '0;
        btype_q  <= f_hit ? ent_q[f_set][f_way].btype : '0;
        pred_q   <= f_hit & ent_q[f_set][f_way].ctr[1];
      end
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end else begin
        if (lk_touch) plru_q[f_set] <= plru_touch(plru_q[f_set], f_way);
        if (w_touch)  plru_q[u_set] <= plru_touch(plru_w_base, w_way);
        if (alloc)    valid_q[u_set][w_way] <= 1'b1;
      end
    end
  end

  // Payload writes are suppressed during reset; flush already blocks them via wr_en.
  always_ff @(posedge clk) begin
    if (rst && w_touch) begin
      ent_q[u_set][w_way] <= wr_ent;
    end
  end

  assign hit        = hit_q;
  assign target     = target_q;
  assign btype      = btype_q;
  assign pred_taken = pred_q;

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Purpose : randomized + directed scoreboard bench for branch_target_buffer_sa.
// Latency : expectations are queued per driven cycle and compared 1 ns after the next rising edge.
// Backpressure: none; the driver never stalls, the monitor drains the queue.
module tb_branch_target_buffer_sa;

  localparam int KEY_W = 29;
  localparam int TGT_W = 30;
  localparam int BT_W  = 2;
  localparam int S     = 8;
  localparam int SB    = 3;
  localparam int W     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fetch_en = 1'b0;
  logic [KEY_W-1:0] fetch_PC = '0;
  logic             load = 1'b0;
  logic [KEY_W-1:0] new_PC = '0;
  logic [TGT_W-1:0] new_target = '0;
  logic [BT_W-1:0]  new_btype = '0;
  logic             new_taken = 1'b0;
  logic             flush = 1'b0;
  logic             hit;
  logic [TGT_W-1:0] target;
  logic [BT_W-1:0]  btype;
  logic             pred_taken;

  always #5 clk = ~clk;

  branch_target_buffer_sa #(
    .KEY_W(KEY_W), .TGT_W(TGT_W), .BTYPE_W(BT_W), .SETS(S), .WAYS(W)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_PC(fetch_PC),
    .load(load), .new_PC(new_PC), .new_target(new_target),
    .new_btype(new_btype), .new_taken(new_taken), .flush(flush),
    .hit(hit), .target(target), .btype(btype), .pred_taken(pred_taken)
  );

  typedef struct {
    bit               h;
    logic [TGT_W-1:0] t;
    logic [BT_W-1:0]  b;
    bit               p;
    string            nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------------------------------------------------- reference model
  // Each set is a list of WAYS slots holding the full key; the PLRU tree is
  // kept as node flags indexed 1..W-1 and walked by halving way ranges.
  bit               mv [S][W];
  logic [KEY_W-1:0] mk [S][W];
  logic [TGT_W-1:0] mt [S][W];
  logic [BT_W-1:0]  mb [S][W];
  int               mc [S][W];
  bit               mp [S][W];
  bit               o_h;
  logic [TGT_W-1:0] o_t;
  logic [BT_W-1:0]  o_b;
  bit               o_p;

  function automatic int set_of(logic [KEY_W-1:0] k);
    return int'(k[SB-1:0]);
  endfunction

  function automatic int find(logic [KEY_W-1:0] k);
    int s;
    s = set_of(k);
    for (int w = 0; w < W; w++) if (mv[s][w] && mk[s][w] == k) return w;
    return -1;
  endfunction

  // flag=1 means "right half is the older one"
  task automatic touch(int s, int way);
    int lo, size, node, half;
    lo = 0; size = W; node = 1;
    while (size > 1) begin
      half = size / 2;
      if (way < lo + half) begin
        mp[s][node] = 1'b1;
        node = 2 * node;
      end else begin
        mp[s][node] = 1'b0;
        lo = lo + half;
        node = 2 * node + 1;
      end
      size = half;
    end
  endtask

  function automatic int victim(int s);
    int lo, size, node, half;
    lo = 0; size = W; node = 1;
    while (size > 1) begin
      half = size / 2;
      if (mp[s][node]) begin
        lo = lo + half;
        node = 2 * node + 1;
      end else begin
        node = 2 * node;
      end
      size = half;
    end
    return lo;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        mv[s][w] = 1'b0;
        mp[s][w] = 1'b0;
      end
  endtask

  // ---------------------------------------------------------- driver
  task automatic step(bit r, bit fe, logic [KEY_W-1:0] fpc, bit ld,
                      logic [KEY_W-1:0] npc, logic [TGT_W-1:0] ntgt,
                      logic [BT_W-1:0] nbt, bit ntk, bit fl, string nm);
    exp_t e;
    int   lh, fs, us, uh, ww;
    bit   do_w, do_alloc;
    @(negedge clk);
    rst = r; fetch_en = fe; fetch_PC = fpc; load = ld; new_PC = npc;
    new_target = ntgt; new_btype = nbt; new_taken = ntk; flush = fl;

    if (!r) begin
      model_clear();
      o_h = 1'b0; o_t = '0; o_b = '0; o_p = 1'b0;
    end else begin
      fs = set_of(fpc);
      us = set_of(npc);
      lh = fe ? find(fpc) : -1;
      if (fe) begin
        o_h = (lh >= 0);
        o_t = (lh >= 0) ? mt[fs][lh] : '0;
        o_b = (lh >= 0) ? mb[fs][lh] : '0;
        o_p = (lh >= 0) && (mc[fs][lh] >= 2);
      end
      do_w = 1'b0; do_alloc = 1'b0; ww = -1;
      if (ld && !fl) begin
        uh = find(npc);
        if (uh >= 0) begin
          do_w = 1'b1; ww = uh;
        end else if (ntk) begin
          do_w = 1'b1; do_alloc = 1'b1;
          for (int w = W - 1; w >= 0; w--) if (!mv[us][w]) ww = w;
          if (ww < 0) ww = victim(us);
        end
      end
      if (fl) begin
        model_clear();
      end else begin
        if (lh >= 0) touch(fs, lh);
        if (do_w) begin
          touch(us, ww);
          if (do_alloc) begin
            mv[us][ww] = 1'b1; mk[us][ww] = npc; mt[us][ww] = ntgt;
            mb[us][ww] = nbt;  mc[us][ww] = 2;
          end else if (ntk) begin
            mt[us][ww] = ntgt; mb[us][ww] = nbt;
            mc[us][ww] = (mc[us][ww] < 3) ? mc[us][ww] + 1 : 3;
          end else begin
            mc[us][ww] = (mc[us][ww] > 0) ? mc[us][ww] - 1 : 0;
          end
        end
      end
    end
    e.h = o_h; e.t = o_t; e.b = o_b; e.p = o_p; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic look(logic [KEY_W-1:0] k, string nm);
    step(1'b1, 1'b1, k, 1'b0, '0, '0, '0, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(logic [KEY_W-1:0] k, logic [TGT_W-1:0] t, logic [BT_W-1:0] b, bit tk);
    step(1'b1, 1'b0, '0, 1'b1, k, t, b, tk, 1'b0, "wr_hold");
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, "reset");
  endtask

  // ---------------------------------------------------------- monitor
  task automatic cmp(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.nm, ".hit"},    32'(hit),        32'(e.h));
        cmp({e.nm, ".target"}, 32'(target),     32'(e.t));
        cmp({e.nm, ".btype"},  32'(btype),      32'(e.b));
        cmp({e.nm, ".pred"},   32'(pred_taken), 32'(e.p));
      end
    end
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    logic [KEY_W-1:0] rk, rn;
    int budget;

    do_reset();
    do_reset();
    look(29'd0, "t1_reset_lookup");

    // write and same-cycle lookup: lookup must not see the write
    step(1'b1, 1'b1, 29'h0AAAAAAA, 1'b1, 29'h0AAAAAAA, 30'h15555555, 2'b01, 1'b1, 1'b0, "t2_same_cycle");
    look(29'h0AAAAAAA, "t2_next_cycle");

    // set-0 fill then one more allocation
    do_reset();
    for (int k = 0; k < 32; k += 8) wr(29'(k), 30'(k + 100), 2'b10, 1'b1);
    wr(29'd32, 30'd132, 2'b11, 1'b1);
    for (int k = 0; k <= 32; k += 8) look(29'(k), "t3_evict");
    do_reset();
    for (int k = 0; k < 32; k += 8) wr(29'(k), 30'(k + 100), 2'b10, 1'b1);
    look(29'd0, "t3_touch0");
    wr(29'd32, 30'd132, 2'b11, 1'b1);
    for (int k = 0; k <= 32; k += 8) look(29'(k), "t3_plru");

    // direction counter
    do_reset();
    wr(29'd5, 30'h5, 2'b01, 1'b1);  look(29'd5, "t4_ctr2");
    wr(29'd5, 30'h9, 2'b10, 1'b0);  look(29'd5, "t4_ctr1");
    wr(29'd5, 30'h9, 2'b10, 1'b0);
    wr(29'd5, 30'h9, 2'b10, 1'b0);  look(29'd5, "t4_ctr0");
    wr(29'd5, 30'h7, 2'b11, 1'b1);  look(29'd5, "t4_ctr1b");
    wr(29'd5, 30'h7, 2'b11, 1'b1);
    wr(29'd5, 30'h8, 2'b01, 1'b1);  look(29'd5, "t4_ctr3");
    wr(29'd5, 30'h8, 2'b01, 1'b0);  look(29'd5, "t4_ctr3dec");
    wr(29'd13, 30'h13, 2'b01, 1'b0); look(29'd13, "t4_nt_miss");

    // fill 16 keys, flush with simultaneous load and lookup
    do_reset();
    for (int k = 0; k < 16; k++) wr(29'(k), 30'(k), 2'(k), 1'b1);
    for (int k = 0; k < 16; k++) look(29'(k), "t5_fill");
    step(1'b1, 1'b1, 29'd3, 1'b1, 29'd3, 30'h3F, 2'b11, 1'b1, 1'b1, "t5_flush_cycle");
    for (int k = 0; k < 16; k++) look(29'(k), "t5_after_flush");

    // reset during lookup, then output hold
    wr(29'd7, 30'h77, 2'b10, 1'b1);
    look(29'd7, "t6_resident");
    step(1'b0, 1'b1, 29'd7, 1'b0, '0, '0, '0, 1'b0, 1'b0, "t6_rst_inflight");
    look(29'd7, "t6_after_rst");
    wr(29'd7, 30'h77, 2'b10, 1'b1);
    look(29'd7, "t6_hit");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 29'($urandom), 1'b0, '0, '0, '0, 1'b0, 1'b0, "t6_hold");

    // randomized traffic over a small key pool so sets conflict
    for (int i = 0; i < 3000; i++) begin
      rk = 29'($urandom_range(0, 47));
      rn = 29'($urandom_range(0, 47));
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 9) != 0), rk,
           ($urandom_range(0, 1) == 1), rn,
           30'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) < 2), "rand");
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
